// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_rst_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   function automatic int cnt_width(input int max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL LOCK flag into the clk domain.
module pll_lock_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL reset / lock-debounce sequencer producing pll_rst, sys_rst_n and ready.
// Define PLL_RST_SEQUENCER_LOSS_CNT_EN to build the lock-loss counter.
module pll_rst_sequencer
   import pll_rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES      = 2,
   parameter int PLL_RST_CYCLES   = 12,
   parameter int LOCK_STABLE_CYC  = 1200,
   parameter int LOCK_TIMEOUT_CYC = 120000,
   parameter int LOSS_CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_lock,
   output logic                  pll_rst,
   output logic                  sys_rst_n,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYC) ? PLL_RST_CYCLES : LOCK_STABLE_CYC;
   localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
   localparam int CNT_W   = cnt_width(MAX_CYC);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             lock_s;

   pll_lock_sync #(
      .STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pll_lock),
      .q    (lock_s)
   );

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         PLL_RST: begin
            if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s)                    state_nxt = STABLE;
            else if (cnt == TIMEOUT_LAST)  state_nxt = PLL_RST;
         end
         STABLE: begin
            if (!lock_s)                   state_nxt = WAIT_LOCK;
            else if (cnt == STABLE_LAST)   state_nxt = RUN;
         end
         RUN: begin
            if (!lock_s) state_nxt = PLL_RST;
         end
         default: state_nxt = PLL_RST;
      endcase
   end

   // Outputs are decoded from state_nxt so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PLL_RST;
         cnt       <= '0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
      end else begin
         state     <= state_nxt;
         // cnt has no role in RUN, so it is held at zero there.
         if ((state_nxt != state) || (state_nxt == RUN)) cnt <= '0;
         else                                            cnt <= cnt + 1'b1;
         pll_rst   <= (state_nxt == PLL_RST);
         sys_rst_n <= (state_nxt == RUN);
         ready     <= (state_nxt == RUN);
      end
   end

`ifdef PLL_RST_SEQUENCER_LOSS_CNT_EN
   logic                  loss_evt;
   logic [LOSS_CNT_W-1:0] loss_q;

   assign loss_evt = (state == RUN) && !lock_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= '0;
      end else if (loss_evt && (loss_q != '1)) begin
         loss_q <= loss_q + 1'b1;
      end
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Self-checking bench for pll_rst_sequencer: behavioural model plus directed scenarios.
module tb_pll_rst_sequencer;

   localparam int SYNC_STAGES      = 2;
   localparam int PLL_RST_CYCLES   = 4;
   localparam int LOCK_STABLE_CYC  = 8;
   localparam int LOCK_TIMEOUT_CYC = 32;
   localparam int LOSS_CNT_W       = 8;
   localparam int LOSS_MAX         = (1 << LOSS_CNT_W) - 1;

`ifdef PLL_RST_SEQUENCER_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic                  clk;
   logic                  rst_n;
   logic                  pll_lock;
   logic                  pll_rst;
   logic                  sys_rst_n;
   logic                  ready;
   logic [LOSS_CNT_W-1:0] lock_loss_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pll_rst_sequencer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .PLL_RST_CYCLES  (PLL_RST_CYCLES),
      .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
      .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
      .LOSS_CNT_W      (LOSS_CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_lock     (pll_lock),
      .pll_rst      (pll_rst),
      .sys_rst_n    (sys_rst_n),
      .ready        (ready),
      .lock_loss_cnt(lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: phase of the sequence plus cycles spent in it; lock seen through a delay line.
   localparam int PH_RESET = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_DEB   = 2;
   localparam int PH_UP    = 3;

   int phase  = PH_RESET;
   int dwell  = 0;
   int losses = 0;
   bit lock_hist [SYNC_STAGES];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase  = PH_RESET;
         dwell  = 0;
         losses = 0;
         for (int i = 0; i < SYNC_STAGES; i++) lock_hist[i] = 1'b0;
      end else begin
         bit seen;
         seen = lock_hist[SYNC_STAGES-1];
         for (int i = SYNC_STAGES - 1; i > 0; i--) lock_hist[i] = lock_hist[i-1];
         lock_hist[0] = pll_lock;
         dwell = dwell + 1;
         if (phase == PH_RESET) begin
            if (dwell == PLL_RST_CYCLES) begin phase = PH_WAIT; dwell = 0; end
         end else if (phase == PH_WAIT) begin
            if (seen)                            begin phase = PH_DEB;   dwell = 0; end
            else if (dwell == LOCK_TIMEOUT_CYC)  begin phase = PH_RESET; dwell = 0; end
         end else if (phase == PH_DEB) begin
            if (!seen)                           begin phase = PH_WAIT;  dwell = 0; end
            else if (dwell == LOCK_STABLE_CYC)   begin phase = PH_UP;    dwell = 0; end
         end else begin
            if (!seen) begin
               phase = PH_RESET;
               dwell = 0;
               if (LOSS_EN && losses < LOSS_MAX) losses = losses + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_pll_rst",   32'(pll_rst),       32'(phase == PH_RESET));
      check("cmp_sys_rst_n", 32'(sys_rst_n),     32'(phase == PH_UP));
      check("cmp_ready",     32'(ready),         32'(phase == PH_UP));
      check("cmp_loss_cnt",  32'(lock_loss_cnt), losses);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // From a reset release with pll_lock held high: 4 PLL_RST, 1 WAIT, 8 STABLE cycles.
   task automatic relock_after_reset(input string tag);
      tick(4);
      check({tag, "_pll_rst_fall"}, 32'(pll_rst), 32'd0);
      tick(8);
      check({tag, "_not_yet"}, 32'(sys_rst_n), 32'd0);
      tick(1);
      check({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd1);
      check({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete at t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_loss;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      tick(2);
      check("rst_pll_rst",   32'(pll_rst),       32'd1);
      check("rst_sys_rst_n", 32'(sys_rst_n),     32'd0);
      check("rst_ready",     32'(ready),         32'd0);
      check("rst_loss_cnt",  32'(lock_loss_cnt), 32'd0);

      rst_n = 1'b1;
      tick(3);
      check("rel_pll_rst_hold", 32'(pll_rst), 32'd1);
      tick(1);
      check("rel_pll_rst_fall", 32'(pll_rst), 32'd0);

      // Nominal lock from WAIT_LOCK entry: release 2+8+1 cycles later.
      pll_lock = 1'b1;
      tick(10);
      check("nom_not_yet", 32'(sys_rst_n), 32'd0);
      tick(1);
      check("nom_sys_rst_n", 32'(sys_rst_n), 32'd1);
      check("nom_ready",     32'(ready),     32'd1);

      // First lock loss in RUN.
      pll_lock = 1'b0;
      tick(2);
      check("loss1_pre", 32'(sys_rst_n), 32'd1);
      tick(1);
      check("loss1_sys_rst_n", 32'(sys_rst_n),     32'd0);
      check("loss1_pll_rst",   32'(pll_rst),       32'd1);
      check("loss1_cnt",       32'(lock_loss_cnt), LOSS_EN ? 32'd1 : 32'd0);
      tick(4);
      check("loss1_wait", 32'(pll_rst), 32'd0);

      // Debounce: 5 high, 1 low, then high; release 11 cycles after the final rise.
      pll_lock = 1'b1;
      tick(5);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(5);
      check("dbnc_no_early", 32'(sys_rst_n), 32'd0);
      tick(5);
      check("dbnc_not_yet", 32'(sys_rst_n), 32'd0);
      tick(1);
      check("dbnc_release", 32'(sys_rst_n), 32'd1);

      // Timeout: lock stuck low, pll_rst pulses 4 cycles every 36.
      pll_lock = 1'b0;
      tick(3);
      check("to_loss_pll_rst", 32'(pll_rst), 32'd1);
      tick(4);
      check("to_first_wait", 32'(pll_rst), 32'd0);
      for (int r = 0; r < 3; r++) begin
         tick(31);
         check("to_wait_end",  32'(pll_rst), 32'd0);
         tick(1);
         check("to_retry_rise", 32'(pll_rst), 32'd1);
         tick(3);
         check("to_retry_hold", 32'(pll_rst), 32'd1);
         tick(1);
         check("to_retry_fall", 32'(pll_rst), 32'd0);
      end
      check("to_loss_cnt", 32'(lock_loss_cnt), LOSS_EN ? 32'd2 : 32'd0);

      // Async reset mid-STABLE.
      pll_lock = 1'b1;
      tick(5);
      #2 rst_n = 1'b0;
      #1;
      check("arst_stable_pll_rst",   32'(pll_rst),       32'd1);
      check("arst_stable_sys_rst_n", 32'(sys_rst_n),     32'd0);
      check("arst_stable_loss_cnt",  32'(lock_loss_cnt), 32'd0);
      tick(1);
      rst_n = 1'b1;
      relock_after_reset("arst_stable");

      // Async reset mid-RUN drops sys_rst_n without waiting for a clock.
      #2 rst_n = 1'b0;
      #1;
      check("arst_run_sys_rst_n", 32'(sys_rst_n), 32'd0);
      check("arst_run_ready",     32'(ready),     32'd0);
      check("arst_run_pll_rst",   32'(pll_rst),   32'd1);
      tick(1);
      rst_n = 1'b1;
      relock_after_reset("arst_run");

      // 256 single-cycle drops in RUN: counter saturates at 255.
      for (int k = 1; k <= 256; k++) begin
         pll_lock = 1'b0;
         tick(1);
         pll_lock = 1'b1;
         tick(2);
         exp_loss = LOSS_EN ? ((k > LOSS_MAX) ? LOSS_MAX : k) : 0;
         check("sat_sys_rst_n", 32'(sys_rst_n),     32'd0);
         check("sat_loss_cnt",  32'(lock_loss_cnt), exp_loss);
         tick(13);
         check("sat_relock", 32'(sys_rst_n), 32'd1);
      end
      check("sat_final", 32'(lock_loss_cnt), LOSS_EN ? 32'd255 : 32'd0);

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
